dmem_arbiter: RTL and testbench

- Two-requester arbiter and access sequencer placed in front of the single-port DataMemory (dataWidth 32, 64 words, asynchronous read, write on clk when en and we are high).
- Requester 0 is the MIPS core data port; requester 1 is the program/data loader (test or DMA path).
- Each access is granted round-robin and run as one registered memory cycle.
- Read data and a one-cycle ack are returned to the winning requester only.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 47 ++++
 rtl/dmem_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Access sequencer states: arbitrate, run one memory cycle, acknowledge.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Requester indices: the core data port and the program/data loader.
  localparam int REQ_CORE   = 0;
  localparam int REQ_LOADER = 1;
  localparam int NUM_REQ    = 2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and DataMemory signals of the arbiter, bundled for port lists.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32
);

  // Requester 0 (core)
  logic                  req0;
  logic                  we0;
  logic [DATA_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  ack0;
  logic [DATA_WIDTH-1:0] rdata0;

  // Requester 1 (loader)
  logic                  req1;
  logic                  we1;
  logic [DATA_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  ack1;
  logic [DATA_WIDTH-1:0] rdata1;

  // DataMemory side
  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_di;
  logic [DATA_WIDTH-1:0] mem_do;

  // Arbiter view.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_do,
    output ack0, rdata0, ack1, rdata1,
    output mem_en, mem_we, mem_addr, mem_di
  );

  // Requesters-plus-memory view.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_do,
    input  ack0, rdata0, ack1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_di
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick; on contention the requester
// that did not win last time is chosen.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_valid,
  output logic o_grant
);

  // Pick a winner from the current requests and the previous winner.
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = 1'b0;
    if (i_req0 && i_req1) begin
      o_grant = ~i_last_grant;
    end else if (i_req1) begin
      o_grant = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter and access sequencer in front of the single-port
// DataMemory. Each granted access takes IDLE -> ACCESS -> DONE; the memory
// sees only latched values, and ack/rdata go back to the winner only.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  state_t                r_state;
  state_t                w_state_next;

  logic                  r_owner;
  logic                  r_we;
  logic                  r_last_grant;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  r_ack   [NUM_REQ];
  logic [DATA_WIDTH-1:0] r_rdata [NUM_REQ];

  logic [NUM_REQ-1:0]    w_req;
  logic [NUM_REQ-1:0]    w_owner_sel;
  logic                  w_grant_valid;
  logic                  w_grant;
  logic                  w_latch;
  logic                  w_complete;
  logic                  w_mem_en;
  logic                  w_we_sel;
  logic [DATA_WIDTH-1:0] w_addr_sel;
  logic [DATA_WIDTH-1:0] w_wdata_sel;

  assign w_req = {bus.req1, bus.req0};

  rr_arb2 u_rr_arb2 (
    .i_req0       (w_req[REQ_CORE]),
    .i_req1       (w_req[REQ_LOADER]),
    .i_last_grant (r_last_grant),
    .o_valid      (w_grant_valid),
    .o_grant      (w_grant)
  );

  // Route the winning requester's command fields toward the latch.
  always_comb begin
    w_we_sel    = bus.we0;
    w_addr_sel  = bus.addr0;
    w_wdata_sel = bus.wdata0;
    if (w_grant) begin
      w_we_sel    = bus.we1;
      w_addr_sel  = bus.addr1;
      w_wdata_sel = bus.wdata1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus latch/complete strobes and memory enable.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_complete   = 1'b0;
    w_mem_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_valid) begin
          w_latch      = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        w_mem_en     = 1'b1;
        w_complete   = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Reset gates the strobes so a reset landing in ACCESS cannot commit a write.
  assign bus.mem_en   = w_mem_en & ~reset;
  assign bus.mem_we   = w_mem_en & r_we & ~reset;
  assign bus.mem_addr = r_addr;
  assign bus.mem_di   = r_wdata;

  // Capture the granted command; the address is wrapped to the memory depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_last_grant <= 1'b1;
    end else if (w_latch) begin
      r_owner      <= w_grant;
      r_we         <= w_we_sel;
      r_addr       <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_addr_sel[ADDR_WIDTH-1:0]};
      r_wdata      <= w_wdata_sel;
      r_last_grant <= w_grant;
    end
  end

  assign w_owner_sel = r_owner ? 2'b10 : 2'b01;

  // Per-requester ack pulse and read-data holding register.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
      // Ack is raised for the DONE cycle only; rdata is loaded on reads only.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_ack[gi]   <= 1'b0;
          r_rdata[gi] <= '0;
        end else begin
          r_ack[gi] <= w_complete & w_owner_sel[gi];
          if (w_complete && w_owner_sel[gi] && !r_we) begin
            r_rdata[gi] <= bus.mem_do;
          end
        end
      end
    end
  endgenerate

  assign bus.ack0   = r_ack[REQ_CORE];
  assign bus.rdata0 = r_rdata[REQ_CORE];
  assign bus.ack1   = r_ack[REQ_LOADER];
  assign bus.rdata1 = r_rdata[REQ_LOADER];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural DataMemory.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(32)) bus ();

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // DataMemory: 64 words, asynchronous read, write on clk when en & we.
  logic [31:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
  end
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[5:0]] <= bus.mem_di;
  end
  assign bus.mem_do = mem[bus.mem_addr[5:0]];

  typedef struct {
    int          who;
    bit          is_read;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int          who;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int ack0_count = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(int who, bit req, bit we, logic [31:0] a, logic [31:0] d);
    if (who == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  function automatic logic get_ack(int who);
    return (who == 0) ? bus.ack0 : bus.ack1;
  endfunction

  // Scoreboard check for one observed ack.
  task automatic take_ack(int who, logic [31:0] rd);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack: got ack%0d expected none", who);
    end else begin
      e = sb.pop_front();
      chk("grant_owner", who, e.who);
      if (e.is_read) chk("rdata", rd, e.rdata);
      $display("txn: ack to req%0d read=%0d rdata=%h", who, e.is_read, rd);
    end
  endtask

  // Monitor: acks, overlap, address upper bits.
  always @(negedge clk) begin
    if (bus.mem_en) chk("mem_addr_hi", bus.mem_addr & 32'hFFFF_FFC0, 32'h0);
    if (bus.ack0 && bus.ack1) chk("ack_overlap", {31'b0, bus.ack1}, 32'h0);
    if (bus.ack0) begin
      ack0_count++;
      take_ack(0, bus.rdata0);
    end
    if (bus.ack1) take_ack(1, bus.rdata1);
  end

  // One isolated access with exact latency checks.
  task automatic do_single(int who, bit we, logic [31:0] a, logic [31:0] d, logic [31:0] exp);
    sb_t e;
    @(negedge clk);
    drive(who, 1'b1, we, a, d);
    e.who = who; e.is_read = !we; e.rdata = exp;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    chk("lat_early", get_ack(who), 0);
    @(posedge clk); @(negedge clk);
    chk("lat_ack", get_ack(who), 1);
    chk("other_ack", get_ack(1 - who), 0);
    drive(who, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("ack_drop", get_ack(who), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    sb_t  e;
    int   c0, c1, n0, n1, base;

    vt[0] = '{1, 1'b1, 32'd5,  32'hDEAD_BEEF, 32'h0};
    vt[1] = '{0, 1'b0, 32'd5,  32'h0,         32'hDEAD_BEEF};
    vt[2] = '{0, 1'b1, 32'd70, 32'h1234_5678, 32'h0};
    vt[3] = '{1, 1'b0, 32'd6,  32'h0,         32'h1234_5678};
    vt[4] = '{1, 1'b1, 32'd9,  32'hA5A5_A5A5, 32'h0};
    vt[5] = '{0, 1'b0, 32'd73, 32'h0,         32'hA5A5_A5A5};
    vt[6] = '{1, 1'b1, 32'd1,  32'h1111_1111, 32'h0};
    vt[7] = '{0, 1'b1, 32'd2,  32'h2222_2222, 32'h0};
    vt[8] = '{1, 1'b0, 32'd40, 32'h0,         32'h1000_0028};

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", bus.ack0, 0);
    chk("rst_ack1", bus.ack1, 0);
    chk("rst_rdata0", bus.rdata0, 32'h0);
    chk("rst_rdata1", bus.rdata1, 32'h0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    reset = 1'b0;

    // Table of isolated accesses.
    for (int i = 0; i < 9; i++) begin
      do_single(vt[i].who, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp);
    end
    chk("mem6_wrap", mem[6], 32'h1234_5678);

    // Simultaneous first requests after reset: requester 0 first.
    @(negedge clk); reset = 1'b1;
    @(posedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd1, 32'h0);
    drive(1, 1'b1, 1'b0, 32'd2, 32'h0);
    e.who = 0; e.is_read = 1'b1; e.rdata = 32'h1111_1111; sb.push_back(e);
    e.who = 1; e.is_read = 1'b1; e.rdata = 32'h2222_2222; sb.push_back(e);
    c0 = -1; c1 = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack0 && c0 < 0) begin
        c0 = cyc;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (bus.ack1) begin
        c1 = cyc;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        break;
      end
    end
    chk("first_ack_lat", c0, 1);
    chk("ack1_gap", c1 - c0, 3);

    // Continuous contention: 0 writes, 1 reads back; order must alternate.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd20, 32'hC0DE_0000);
    drive(1, 1'b1, 1'b0, 32'd20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      e.who = 0; e.is_read = 1'b0; e.rdata = 32'h0; sb.push_back(e);
      e.who = 1; e.is_read = 1'b1; e.rdata = 32'hC0DE_0000 + 32'(i); sb.push_back(e);
    end
    n0 = 0; n1 = 0;
    for (int cyc = 0; cyc < 60 && (n0 < 4 || n1 < 4); cyc++) begin
      @(posedge clk); @(negedge clk);
      if (bus.ack0) begin
        n0++;
        if (n0 < 4) drive(0, 1'b1, 1'b1, 32'd20 + 32'(n0), 32'hC0DE_0000 + 32'(n0));
        else        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (bus.ack1) begin
        n1++;
        if (n1 < 4) drive(1, 1'b1, 1'b0, 32'd20 + 32'(n1), 32'h0);
        else        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    chk("contend_n0", n0, 4);
    chk("contend_n1", n1, 4);

    // Reset during ACCESS aborts a write over 0xA5A5A5A5 at addr 9.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd9, 32'hFFFF_FFFF);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_mem_en", bus.mem_en, 0);
    chk("abort_mem_we", bus.mem_we, 0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("abort_mem9", mem[9], 32'hA5A5_A5A5);
    chk("abort_ack0", bus.ack0, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    do_single(0, 1'b0, 32'd9, 32'h0, 32'hA5A5_A5A5);

    // One-cycle req0 pulse while requester 1 is in ACCESS is never granted.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'd6, 32'h0);
    e.who = 1; e.is_read = 1'b1; e.rdata = 32'h1234_5678; sb.push_back(e);
    @(posedge clk); @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
    base = ack0_count;
    @(posedge clk); @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("pulse_ack1", bus.ack1, 1);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (6) @(negedge clk);
    chk("pulse_no_ack0", ack0_count - base, 0);
    chk("rdata1_hold", bus.rdata1, 32'h1234_5678);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
